fan_out_collector: RTL and testbench

- Downstream stage of the fan_adder reduction network.
- Each cycle the network presents NUM_OUT result lanes plus a mask of the lanes that hold completed reductions.
- This block accepts one such bundle per handshake and serialises the masked lanes, lowest lane first, into a single-result valid/ready stream.
- Each result is sign- or zero-extended to DW_OUT and tagged with its lane number, a running index and a row-set-end flag.

---
 rtl/fan_pkg.sv | 30 +++
 rtl/fan_lsb_pick.sv | 32 +++
 rtl/fan_out_collector.sv | 158 +++++++++++++++
 tb/tb_fan_out_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// ============================================================================
// Module  : fan_pkg
// Purpose : Shared types, constants and helpers for the fan_adder family.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fan_pkg;

    localparam int c_dw_data = 8;
    localparam int c_num_out = 4;
    localparam int c_dw_out  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } fan_state_e;

    // Lane tag width; never narrower than one bit.
    function automatic int lane_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

    function automatic int ext_w(input int dw_out, input int dw_data);
        return dw_out - dw_data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fan_lsb_pick.sv
// ============================================================================
// Module  : fan_lsb_pick
// Purpose : Lowest-set-bit priority encoder: index, one-hot and single-bit flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_lsb_pick #(
    parameter int NUM_OUT = 4,
    parameter int LANE_W  = 2
) (
    input  logic [NUM_OUT-1:0] mask,
    output logic [LANE_W-1:0]  lsb_idx,
    output logic [NUM_OUT-1:0] lsb_onehot,
    output logic               single
);

    always_comb begin
        lsb_idx = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lsb_idx = LANE_W'(i);
            end
        end
    end

    assign lsb_onehot = mask & (~mask + NUM_OUT'(1));
    assign single     = (mask != '0) && ((mask & (mask - NUM_OUT'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/fan_out_collector.sv
// ============================================================================
// Module  : fan_out_collector
// Purpose : Serialises masked result lanes of a bundle into a tagged stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_out_collector
    import fan_pkg::*;
#(
    parameter int DW_DATA = c_dw_data,
    parameter int NUM_OUT = c_num_out,
    parameter int DW_OUT  = c_dw_out,
    parameter int SIGNED  = 1,
    parameter int LANE_W  = lane_w(NUM_OUT),
    parameter int IDX_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW_DATA*NUM_OUT-1:0] in_data,
    input  logic [NUM_OUT-1:0]         in_mask,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW_OUT-1:0]          out_data,
    output logic [LANE_W-1:0]          out_lane,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       busy
);

    localparam int c_ext_w = ext_w(DW_OUT, DW_DATA);

    fan_state_e                 r_state;
    fan_state_e                 w_state_nxt;
    logic [NUM_OUT-1:0]         r_pend;
    logic [NUM_OUT-1:0]         r_clr;
    logic                       r_single;
    logic [DW_DATA*NUM_OUT-1:0] r_data;
    logic                       r_last;

    logic                       w_in_fire;
    logic                       w_out_fire;
    logic [NUM_OUT-1:0]         w_pend_nxt;
    logic [DW_DATA*NUM_OUT-1:0] w_data_nxt;
    logic                       w_last_nxt;
    logic [IDX_W-1:0]           w_idx_nxt;
    logic [LANE_W-1:0]          w_pick_idx;
    logic [NUM_OUT-1:0]         w_pick_clr;
    logic                       w_pick_single;
    logic [DW_DATA-1:0]         w_lane_raw;
    logic [DW_OUT-1:0]          w_ext;

    // r_clr/r_single describe the beat currently on the output, so the
    // handshake logic never has to re-encode the pending mask.
    assign in_ready   = (r_state == IDLE) || (out_ready && r_single);
    assign out_valid  = (r_state == DRAIN);
    assign busy       = (r_state == DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = w_out_fire ? (r_pend & ~r_clr) : r_pend;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        if (w_in_fire) begin
            w_pend_nxt = in_mask;
            w_data_nxt = in_data;
            w_last_nxt = in_last;
        end
        case (r_state)
            IDLE:    if (w_pend_nxt != '0) w_state_nxt = DRAIN;
            DRAIN:   if (w_pend_nxt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt = out_idx;
        if (w_out_fire) begin
            w_idx_nxt = out_last ? '0 : out_idx + IDX_W'(1);
        end
        if (w_in_fire && (in_mask == '0) && in_last) begin
            w_idx_nxt = '0;
        end
    end

    fan_lsb_pick #(
        .NUM_OUT (NUM_OUT),
        .LANE_W  (LANE_W)
    ) u_pick (
        .mask       (w_pend_nxt),
        .lsb_idx    (w_pick_idx),
        .lsb_onehot (w_pick_clr),
        .single     (w_pick_single)
    );

    always_comb begin
        w_lane_raw = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_pick_idx == LANE_W'(i)) begin
                w_lane_raw = w_data_nxt[i*DW_DATA +: DW_DATA];
            end
        end
    end

    generate
        if (c_ext_w == 0) begin : g_ext_none
            assign w_ext = w_lane_raw;
        end else if (SIGNED != 0) begin : g_ext_sign
            assign w_ext = {{c_ext_w{w_lane_raw[DW_DATA-1]}}, w_lane_raw};
        end else begin : g_ext_zero
            assign w_ext = {{c_ext_w{1'b0}}, w_lane_raw};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= '0;
            r_clr    <= '0;
            r_single <= 1'b0;
            r_data   <= '0;
            r_last   <= 1'b0;
            out_data <= '0;
            out_lane <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_clr    <= w_pick_clr;
            r_single <= w_pick_single;
            r_data   <= w_data_nxt;
            r_last   <= w_last_nxt;
            out_idx  <= w_idx_nxt;
            if (w_pend_nxt != '0) begin
                out_data <= w_ext;
                out_lane <= w_pick_idx;
                out_last <= w_last_nxt && w_pick_single;
            end else begin
                out_last <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fan_out_collector.sv
// ============================================================================
// Module  : tb_fan_out_collector
// Purpose : Self-checking bench; two DUT variants share stimulus and a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fan_out_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_lane;
    logic [7:0]  a_out_idx;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_lane;
    logic [1:0]  b_out_idx;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] val;
        int         lane;
        bit         last;
        int         idx;
    } beat_t;

    beat_t q[$];
    int    cnt = 0;

    always #5 clk = ~clk;

    fan_out_collector #(
        .DW_DATA(8), .NUM_OUT(4), .DW_OUT(16), .SIGNED(1), .LANE_W(2), .IDX_W(8)
    ) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_lane(a_out_lane), .out_idx(a_out_idx), .out_last(a_out_last),
        .busy(a_busy)
    );

    fan_out_collector #(
        .DW_DATA(8), .NUM_OUT(4), .DW_OUT(16), .SIGNED(0), .LANE_W(2), .IDX_W(2)
    ) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_lane(b_out_lane), .out_idx(b_out_idx), .out_last(b_out_last),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [7:0] v);
        return (v >= 8'd128) ? (32'(v) + 32'hFF00) : 32'(v);
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input bit r, input bit v, input logic [31:0] d,
                         input logic [3:0] m, input bit l, input bit ordy);
        bit    exp_rdy, ofire, ifire;
        int    nb, k;
        beat_t bt;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; in_mask = m; in_last = l; out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || ((q.size() == 1) && ordy);
        chk("a_in_ready", a_in_ready, exp_rdy);
        chk("b_in_ready", b_in_ready, exp_rdy);
        chk("a_out_valid", a_out_valid, q.size() != 0);
        chk("a_busy", a_busy, q.size() != 0);
        chk("b_out_valid", b_out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("a_out_data", a_out_data, sext(q[0].val));
            chk("b_out_data", b_out_data, 32'(q[0].val));
            chk("a_out_lane", a_out_lane, q[0].lane);
            chk("b_out_lane", b_out_lane, q[0].lane);
            chk("a_out_idx", a_out_idx, q[0].idx % 256);
            chk("b_out_idx", b_out_idx, q[0].idx % 4);
            chk("a_out_last", a_out_last, q[0].last);
            chk("b_out_last", b_out_last, q[0].last);
        end else begin
            chk("a_idle_idx", a_out_idx, cnt % 256);
            chk("b_idle_idx", b_out_idx, cnt % 4);
        end
        if (r) begin
            q.delete();
            cnt = 0;
        end else begin
            ofire = (q.size() != 0) && ordy;
            ifire = v && exp_rdy;
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                nb = $countones(m);
                k  = 0;
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) begin
                        k++;
                        bt.val  = d[i*8 +: 8];
                        bt.lane = i;
                        bt.idx  = cnt;
                        bt.last = l && (k == nb);
                        q.push_back(bt);
                        cnt++;
                        if (bt.last) cnt = 0;
                    end
                end
                if ((m == 4'b0000) && l) cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 4'h0, 0, ordy);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_lane", a_out_lane, 0);
        chk("rst_out_idx", a_out_idx, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_b_out_valid", b_out_valid, 0);

        // Basic drain
        cycle(0, 1, 32'h7F33FE05, 4'b1011, 1, 1);
        idle(4, 1);
        // Backpressure on the same bundle
        cycle(0, 1, 32'h7F33FE05, 4'b1011, 1, 1);
        cycle(0, 0, 32'h0, 4'h0, 0, 0);
        idle(3, 0);
        idle(4, 1);
        // Back-to-back bundles
        cycle(0, 1, 32'h00000010, 4'b0001, 0, 1);
        cycle(0, 1, 32'h00018000, 4'b0110, 1, 1);
        idle(4, 1);
        // Bring idx to 5, then a zero-mask last bundle clears it
        cycle(0, 1, 32'h04030201, 4'b1111, 0, 1);
        idle(4, 1);
        cycle(0, 1, 32'h00000006, 4'b0001, 0, 1);
        idle(2, 1);
        cycle(0, 1, 32'h00000000, 4'b0000, 1, 1);
        cycle(0, 1, 32'h00000080, 4'b0001, 0, 1);
        idle(3, 1);
        // Reset mid-drain
        cycle(0, 1, 32'h44332211, 4'b1111, 0, 1);
        cycle(0, 0, 32'h0, 4'h0, 0, 1);
        cycle(1, 0, 32'h0, 4'h0, 0, 1);
        idle(4, 1);
        // Index wrap on the narrow-index instance
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 32'h11111111 * (i + 1), 4'b0100, 0, 1);
            cycle(0, 0, 32'h0, 4'h0, 0, 1);
        end
        idle(2, 1);

        for (int n = 0; n < 3000; n++) begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) m = 4'h0;
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom(),
                  m, $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
        end
        idle(8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
